cable_input_conditioner: RTL and testbench

CABLE_INPUT_CONDITIONER -- requirements
Module: cable_input_conditioner

---
 rtl/cable_input_conditioner.sv | 76 +++++++
 tb/tb_cable_input_conditioner.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cable_input_conditioner.sv
// Button/cable front end: per-input 2-flop synchronizer and debouncer, one strobe
// per accepted button press with the cable levels captured on that same edge.
module cable_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       cable1_raw,
  input  logic       cable2_raw,
  output logic       pulsed,
  output logic       cable1,
  output logic       cable2,
  output logic [1:0] press_idx,
  output logic       seq_done
);

  localparam logic [7:0] TC = 8'(DEBOUNCE_CYCLES - 1);

  // Channel 0 = button, 1 = cable 1, 2 = cable 2.
  logic [2:0] raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] deb;
  logic [2:0] deb_nxt;
  logic [7:0] cnt     [3];
  logic [7:0] cnt_nxt [3];
  logic [1:0] press_cnt;
  logic       accept;

  assign raw = {cable2_raw, cable1_raw, btn_raw};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      deb_nxt[i] = deb[i];
      cnt_nxt[i] = '0;
      if (sync2[i] != deb[i]) begin
        if (cnt[i] >= TC) deb_nxt[i] = sync2[i];
        else              cnt_nxt[i] = cnt[i] + 8'd1;
      end
    end
  end

  // Cables are captured from their next debounced value so a cable settling on
  // the press edge is reported at its new level.
  assign accept = ~deb[0] & deb_nxt[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      deb       <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
      pulsed    <= 1'b0;
      seq_done  <= 1'b0;
      cable1    <= 1'b0;
      cable2    <= 1'b0;
      press_idx <= 2'd0;
      press_cnt <= 2'd0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      deb      <= deb_nxt;
      for (int i = 0; i < 3; i++) cnt[i] <= cnt_nxt[i];
      pulsed   <= accept;
      seq_done <= accept && (press_cnt == 2'd3);
      if (accept) begin
        cable1    <= deb_nxt[1];
        cable2    <= deb_nxt[2];
        press_idx <= press_cnt;
        press_cnt <= press_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_cable_input_conditioner.sv
// Directed bench for cable_input_conditioner at DEBOUNCE_CYCLES = 4.
module tb_cable_input_conditioner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_raw = 1'b0;
  logic       cable1_raw = 1'b0;
  logic       cable2_raw = 1'b0;
  logic       pulsed;
  logic       cable1;
  logic       cable2;
  logic [1:0] press_idx;
  logic       seq_done;

  int n_total = 0;
  int n_pass  = 0;

  cable_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .cable1_raw(cable1_raw),
    .cable2_raw(cable2_raw),
    .pulsed    (pulsed),
    .cable1    (cable1),
    .cable2    (cable2),
    .press_idx (press_idx),
    .seq_done  (seq_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       c1;
    logic       c2;
    logic [1:0] idx;
    logic       seq;
  } press_vec_t;

  press_vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: act=%0d exp=%0d", name, act, exp);
  endtask

  // Runs `window` edges; k = 0 is the first edge after the call.
  task automatic measure(input int window, output int npulse, output int first,
                         output logic c1, output logic c2, output logic [1:0] idx,
                         output int nseq, output logic seq_at_pulse);
    npulse = 0; first = -1; nseq = 0;
    c1 = 1'b0; c2 = 1'b0; idx = 2'd0; seq_at_pulse = 1'b0;
    for (int k = 0; k < window; k++) begin
      tick();
      if (pulsed) begin
        npulse++;
        if (first < 0) begin
          first = k; c1 = cable1; c2 = cable2; idx = press_idx; seq_at_pulse = seq_done;
        end
      end
      if (seq_done) nseq++;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pulsed"},    int'(pulsed),    0);
    check({tag, "_seq_done"},  int'(seq_done),  0);
    check({tag, "_cable1"},    int'(cable1),    0);
    check({tag, "_cable2"},    int'(cable2),    0);
    check({tag, "_press_idx"}, int'(press_idx), 0);
  endtask

  initial begin
    int np, first, nseq;
    logic c1, c2, sq;
    logic [1:0] idx;

    vecs[0] = '{c1: 1'b0, c2: 1'b0, idx: 2'd0, seq: 1'b0};
    vecs[1] = '{c1: 1'b0, c2: 1'b1, idx: 2'd1, seq: 1'b0};
    vecs[2] = '{c1: 1'b1, c2: 1'b0, idx: 2'd2, seq: 1'b0};
    vecs[3] = '{c1: 1'b1, c2: 1'b1, idx: 2'd3, seq: 1'b1};
    vecs[4] = '{c1: 1'b1, c2: 1'b1, idx: 2'd0, seq: 1'b0};

    // Reset, then idle.
    reset = 1'b1;
    wait_cycles(2);
    check_outputs_zero("reset");
    reset = 1'b0;
    measure(20, np, first, c1, c2, idx, nseq, sq);
    check("idle_pulses", np, 0);

    // First press with cables 1/0: pulse after edge N+5 only.
    cable1_raw = 1'b1; cable2_raw = 1'b0;
    wait_cycles(10);
    btn_raw = 1'b1;
    measure(20, np, first, c1, c2, idx, nseq, sq);
    check("p1_count",  np, 1);
    check("p1_offset", first, 5);
    check("p1_cable1", int'(c1), 1);
    check("p1_cable2", int'(c2), 0);
    check("p1_idx",    int'(idx), 0);
    check("p1_seq",    nseq, 0);
    btn_raw = 1'b0;
    wait_cycles(10);

    // Bouncing press: 2-cycle toggles never qualify, the final hold does once.
    np = 0;
    for (int t = 0; t < 12; t++) begin
      btn_raw = ((t / 2) % 2 == 0);
      tick();
      if (pulsed) np++;
    end
    btn_raw = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (pulsed) np++;
    end
    check("bounce_count", np, 1);
    check("bounce_idx", int'(press_idx), 1);
    btn_raw = 1'b0;
    wait_cycles(10);

    // 3-cycle glitch (one short of the debounce length).
    btn_raw = 1'b1;
    wait_cycles(3);
    btn_raw = 1'b0;
    measure(15, np, first, c1, c2, idx, nseq, sq);
    check("glitch_pulses", np, 0);

    // Cable capture only on accepted presses.
    cable1_raw = 1'b0; cable2_raw = 1'b1;
    wait_cycles(10);
    btn_raw = 1'b1;
    measure(10, np, first, c1, c2, idx, nseq, sq);
    check("hold_count", np, 1);
    check("hold_idx", int'(idx), 2);
    cable1_raw = 1'b1; cable2_raw = 1'b0;
    wait_cycles(10);
    check("held_cable1", int'(cable1), 0);
    check("held_cable2", int'(cable2), 1);
    btn_raw = 1'b0;
    cable1_raw = 1'b1; cable2_raw = 1'b1;
    measure(12, np, first, c1, c2, idx, nseq, sq);
    check("release_pulses", np, 0);
    check("released_cable1", int'(cable1), 0);
    check("released_cable2", int'(cable2), 1);
    check("released_idx", int'(press_idx), 2);

    // Reset at edge N+3 of a press.
    btn_raw = 1'b1;
    wait_cycles(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    btn_raw = 1'b0;
    check_outputs_zero("midreset");
    measure(15, np, first, c1, c2, idx, nseq, sq);
    check("midreset_pulses", np, 0);

    // Five clean presses from a fresh counter.
    for (int v = 0; v < 5; v++) begin
      cable1_raw = vecs[v].c1; cable2_raw = vecs[v].c2;
      wait_cycles(10);
      btn_raw = 1'b1;
      measure(20, np, first, c1, c2, idx, nseq, sq);
      check($sformatf("vec%0d_count", v),  np, 1);
      check($sformatf("vec%0d_offset", v), first, 5);
      check($sformatf("vec%0d_cable1", v), int'(c1), int'(vecs[v].c1));
      check($sformatf("vec%0d_cable2", v), int'(c2), int'(vecs[v].c2));
      check($sformatf("vec%0d_idx", v),    int'(idx), int'(vecs[v].idx));
      check($sformatf("vec%0d_seq", v),    int'(sq), int'(vecs[v].seq));
      check($sformatf("vec%0d_nseq", v),   nseq, int'(vecs[v].seq));
      btn_raw = 1'b0;
      wait_cycles(10);
    end

    // Button held through reset release is debounced afresh.
    btn_raw = 1'b1;
    reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    measure(20, np, first, c1, c2, idx, nseq, sq);
    check("thru_reset_count",  np, 1);
    check("thru_reset_offset", first, 5);
    check("thru_reset_idx",    int'(idx), 0);
    btn_raw = 1'b0;
    wait_cycles(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
